// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-add multiplier that has no arithmetic of its own. It drives
// the shared execute-stage ALU with add and shift-left operations and captures SUM.
module alu_mul_sequencer #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4,
   parameter logic [CTRL_W-1:0] SUM_OP = '0,
   parameter logic [CTRL_W-1:0] SLL_OP = CTRL_W'(1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [WIDTH-1:0]  i_op_a,
   input  logic [WIDTH-1:0]  i_op_b,
   output logic              o_busy,
   output logic              o_done,
   output logic [WIDTH-1:0]  o_result,
   output logic [WIDTH-1:0]  o_alu_op1,
   output logic [WIDTH-1:0]  o_alu_op2,
   output logic [CTRL_W-1:0] o_alu_ctrl,
   input  logic [WIDTH-1:0]  i_alu_sum
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]   r_mplr;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_result;
   logic [WIDTH-1:0]   w_mplrNext;
   logic               w_lastIter;

   assign w_mplrNext = r_mplr >> 1;
   // Stop early once no multiplier bits remain, so short operands finish quickly.
   assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1)) || (w_mplrNext == '0);

   assign o_busy   = (r_state != IDLE);
   assign o_done   = (r_state == DONE);
   assign o_result = r_result;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // ALU drive depends only on state and registers, never on i_start.
   always_comb begin
      w_nextState = r_state;
      o_alu_op1   = '0;
      o_alu_op2   = '0;
      o_alu_ctrl  = SUM_OP;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_nextState = ADD;
            end
         end
         ADD: begin
            o_alu_op1   = r_acc;
            o_alu_op2   = r_mcand;
            w_nextState = SHIFT;
         end
         SHIFT: begin
            o_alu_op1   = r_mcand;
            o_alu_op2   = WIDTH'(1);
            o_alu_ctrl  = SLL_OP;
            w_nextState = w_lastIter ? DONE : ADD;
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplr   <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_acc   <= '0;
                  r_mcand <= i_op_a;
                  r_mplr  <= i_op_b;
                  r_cnt   <= '0;
               end
            end
            ADD: begin
               if (r_mplr[0]) begin
                  r_acc <= i_alu_sum;
               end
            end
            SHIFT: begin
               r_mcand <= i_alu_sum;
               r_mplr  <= w_mplrNext;
               r_cnt   <= r_cnt + CNT_W'(1);
            end
            DONE: begin
               r_result <= r_acc;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: a cycle-level reference model of the
// multiplier's observable behaviour, a bench-side ALU, and directed vectors.
module tb_alu_mul_sequencer;

   localparam int WIDTH = 32;
   localparam int CTRL_W = 4;
   localparam logic [CTRL_W-1:0] SUM_OP = 4'd0;
   localparam logic [CTRL_W-1:0] SLL_OP = 4'd1;

   logic              clk;
   logic              rst;
   logic              start;
   logic [WIDTH-1:0]  opA;
   logic [WIDTH-1:0]  opB;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  result;
   logic [WIDTH-1:0]  aluOp1;
   logic [WIDTH-1:0]  aluOp2;
   logic [CTRL_W-1:0] aluCtrl;
   logic [WIDTH-1:0]  aluSum;

   int cycle = 0;
   int checkCount = 0;
   int passCount = 0;

   alu_mul_sequencer #(
      .WIDTH(WIDTH), .CTRL_W(CTRL_W), .SUM_OP(SUM_OP), .SLL_OP(SLL_OP)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_op_a(opA), .i_op_b(opB),
      .o_busy(busy), .o_done(done), .o_result(result),
      .o_alu_op1(aluOp1), .o_alu_op2(aluOp2), .o_alu_ctrl(aluCtrl),
      .i_alu_sum(aluSum)
   );

   // Stand-in for the shared execute-stage ALU.
   assign aluSum = (aluCtrl == SLL_OP) ? (aluOp1 << aluOp2) : (aluOp1 + aluOp2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                  name, actual, expected, cycle);
      end
   endtask

   function automatic int iterCount(input logic [WIDTH-1:0] b);
      int n = 1;
      for (int i = 0; i < WIDTH; i++) begin
         if (b[i]) n = i + 1;
      end
      return n;
   endfunction

   // Reference model: tracks only whether a product is in flight, how many cycles
   // remain until done, and what the result register must show.
   logic             armed = 1'b0;
   logic             mActive = 1'b0;
   int               mCountdown = 0;
   logic [WIDTH-1:0] mResult = '0;
   logic [WIDTH-1:0] mPending = '0;

   always @(negedge clk) begin
      if (armed) begin
         checkOutput("busy", {31'b0, busy}, {31'b0, mActive});
         checkOutput("done", {31'b0, done}, {31'b0, mActive && (mCountdown == 0)});
         checkOutput("result", result, mResult);
         if (!mActive || mCountdown == 0) begin
            checkOutput("idle_alu_op1", aluOp1, '0);
            checkOutput("idle_alu_op2", aluOp2, '0);
            checkOutput("idle_alu_ctrl", {28'b0, aluCtrl}, {28'b0, SUM_OP});
         end
      end
      if (rst) begin
         armed = 1'b1;
         mActive = 1'b0;
         mCountdown = 0;
         mResult = '0;
      end else if (armed) begin
         if (mActive) begin
            if (mCountdown == 0) begin
               mActive = 1'b0;
               mResult = mPending;
            end else begin
               mCountdown--;
            end
         end else if (start) begin
            mActive = 1'b1;
            mCountdown = 2 * iterCount(opB);
            mPending = opA * opB;
         end
      end
   end

   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output int startCycle);
      start = 1'b1;
      opA = a;
      opB = b;
      startCycle = cycle;
      @(posedge clk);
      #1;
      start = 1'b0;
      opA = $urandom;
      opB = $urandom;
   endtask

   task automatic waitDone(input string name, input int startCycle, input int expOffset,
                           input logic [WIDTH-1:0] expResult);
      logic seen = 1'b0;
      int doneCycle = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            doneCycle = cycle;
         end
      end
      checkOutput({name, "_done_seen"}, {31'b0, seen}, 32'd1);
      if (seen) begin
         checkOutput({name, "_latency"}, doneCycle - startCycle, expOffset);
      end
      @(posedge clk);
      #1;
      checkOutput({name, "_result"}, result, expResult);
   endtask

   initial begin
      int s;
      rst = 1'b1;
      start = 1'b0;
      opA = '0;
      opB = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_busy", {31'b0, busy}, 32'd0);
      checkOutput("reset_done", {31'b0, done}, 32'd0);
      checkOutput("reset_result", result, 32'd0);
      @(posedge clk);
      #1;

      applyStimulus(32'd6, 32'd7, s);
      waitDone("mul_6x7", s, 7, 32'd42);
      applyStimulus(32'hDEADBEEF, 32'd0, s);
      waitDone("mul_by_zero", s, 3, 32'd0);
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, s);
      waitDone("mul_all_ones", s, 65, 32'h00000001);
      applyStimulus(32'hFFFFFFFD, 32'd5, s);
      waitDone("mul_neg3x5", s, 7, 32'hFFFFFFF1);

      applyStimulus(32'd9, 32'd1, s);
      checkOutput("trace_add_ctrl", {28'b0, aluCtrl}, {28'b0, SUM_OP});
      checkOutput("trace_add_op1", aluOp1, 32'd0);
      checkOutput("trace_add_op2", aluOp2, 32'd9);
      @(posedge clk);
      #1;
      checkOutput("trace_shift_ctrl", {28'b0, aluCtrl}, {28'b0, SLL_OP});
      checkOutput("trace_shift_op1", aluOp1, 32'd9);
      checkOutput("trace_shift_op2", aluOp2, 32'd1);
      waitDone("mul_9x1", s, 3, 32'd9);

      applyStimulus(32'd6, 32'd7, s);
      @(posedge clk);
      #1;
      start = 1'b1;
      opA = 32'd1;
      opB = 32'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      waitDone("start_while_busy", s, 7, 32'd42);

      applyStimulus(32'd6, 32'd7, s);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("abort_busy", {31'b0, busy}, 32'd0);
      checkOutput("abort_done", {31'b0, done}, 32'd0);
      checkOutput("abort_result", result, 32'd0);
      applyStimulus(32'd3, 32'd4, s);
      waitDone("mul_3x4", s, 7, 32'd12);

      applyStimulus(32'd5, 32'd5, s);
      waitDone("b2b_first", s, 7, 32'd25);
      applyStimulus(32'h10, 32'h80, s);
      waitDone("b2b_second", s, 17, 32'h800);
      applyStimulus(32'h12345678, 32'h10, s);
      waitDone("b2b_third", s, 11, 32'h23456780);

      repeat (3) @(posedge clk);
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
